stack_unit: RTL and testbench

- Parametrised data/return stack engine for the next-generation stack CPU. It replaces the CPU-internal push/pop tasks with one reusable block.
- The CPU instantiates two copies: a data stack with DEPTH=32 and a return stack with DEPTH=16.
- Each copy exposes the top three entries as registers and executes one stack operation per clock.
- Each copy detects overflow and underflow, with sticky error flags.

---
 rtl/stack_unit_if.sv | 32 +++
 rtl/stack_unit.sv | 180 ++++++++++++++++++
 tb/tb_stack_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/stack_unit_if.sv
// Operation/result bundle between a stack CPU and one stack_unit instance.
// The CPU side drives ops through the master modport; the stack drives results through slave.
interface stack_unit_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             op_valid;
  logic [3:0]       op;
  logic [WIDTH-1:0] push_data;
  logic             clear_err;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic [WIDTH-1:0] ros;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
  logic             op_err;

  modport master (
    output op_valid, op, push_data, clear_err,
    input  tos, nos, ros, count, empty, full, overflow, underflow, op_err
  );

  modport slave (
    input  op_valid, op, push_data, clear_err,
    output tos, nos, ros, count, empty, full, overflow, underflow, op_err
  );
endinterface

// File: rtl/stack_unit.sv
// Stack engine: top three entries in registers, deeper entries spilled to an array
// indexed by count-4, one operation per clock with sticky overflow/underflow flags.
module stack_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  stack_unit_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_PUSH  = 4'd1;
  localparam logic [3:0] OP_DROP  = 4'd2;
  localparam logic [3:0] OP_DUP   = 4'd3;
  localparam logic [3:0] OP_SWAP  = 4'd4;
  localparam logic [3:0] OP_ROT   = 4'd5;
  localparam logic [3:0] OP_REPL1 = 4'd6;
  localparam logic [3:0] OP_REPL2 = 4'd7;
  localparam logic [3:0] OP_CLEAR = 4'd8;

  logic [WIDTH-1:0] tos_q, tos_d;
  logic [WIDTH-1:0] nos_q, nos_d;
  logic [WIDTH-1:0] ros_q, ros_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             err_q;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             mem_we;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] refill;

  logic             is_full;
  logic             rej_ovf;
  logic             rej_unf;

  function automatic logic has_n(input logic [CW-1:0] c, input int n);
    return c >= CW'(n);
  endfunction

  assign is_full = (cnt_q == CW'(DEPTH));

  // Modulo-DEPTH offsets: spill slot is count-3 (old ros lands there), refill slot is count-4.
  assign wr_idx = cnt_q[AW-1:0] + AW'(DEPTH - 3);
  assign rd_idx = cnt_q[AW-1:0] + AW'(DEPTH - 4);
  assign refill = has_n(cnt_q, 4) ? mem_q[rd_idx] : '0;

  always_comb begin
    tos_d   = tos_q;
    nos_d   = nos_q;
    ros_d   = ros_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    rej_ovf = 1'b0;
    rej_unf = 1'b0;
    if (bus.op_valid) begin
      unique case (bus.op)
        OP_PUSH: begin
          if (is_full) begin
            rej_ovf = 1'b1;
          end else begin
            tos_d  = bus.push_data;
            nos_d  = tos_q;
            ros_d  = nos_q;
            cnt_d  = cnt_q + CW'(1);
            mem_we = has_n(cnt_q, 3);
          end
        end
        OP_DROP: begin
          if (!has_n(cnt_q, 1)) begin
            rej_unf = 1'b1;
          end else begin
            tos_d = nos_q;
            nos_d = ros_q;
            ros_d = refill;
            cnt_d = cnt_q - CW'(1);
          end
        end
        OP_DUP: begin
          if (!has_n(cnt_q, 1)) begin
            rej_unf = 1'b1;
          end else if (is_full) begin
            rej_ovf = 1'b1;
          end else begin
            nos_d  = tos_q;
            ros_d  = nos_q;
            cnt_d  = cnt_q + CW'(1);
            mem_we = has_n(cnt_q, 3);
          end
        end
        OP_SWAP: begin
          if (!has_n(cnt_q, 2)) begin
            rej_unf = 1'b1;
          end else begin
            tos_d = nos_q;
            nos_d = tos_q;
          end
        end
        OP_ROT: begin
          if (!has_n(cnt_q, 3)) begin
            rej_unf = 1'b1;
          end else begin
            tos_d = ros_q;
            nos_d = tos_q;
            ros_d = nos_q;
          end
        end
        OP_REPL1: begin
          if (!has_n(cnt_q, 1)) begin
            rej_unf = 1'b1;
          end else begin
            tos_d = bus.push_data;
          end
        end
        OP_REPL2: begin
          if (!has_n(cnt_q, 2)) begin
            rej_unf = 1'b1;
          end else begin
            tos_d = bus.push_data;
            nos_d = ros_q;
            ros_d = refill;
            cnt_d = cnt_q - CW'(1);
          end
        end
        OP_CLEAR: begin
          tos_d = '0;
          nos_d = '0;
          ros_d = '0;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
    // A new rejection in the same cycle as clear_err leaves its flag set.
    ovf_d = (ovf_q & ~bus.clear_err) | rej_ovf;
    unf_d = (unf_q & ~bus.clear_err) | rej_unf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tos_q <= '0;
      nos_q <= '0;
      ros_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      tos_q <= tos_d;
      nos_q <= nos_d;
      ros_q <= ros_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      err_q <= rej_ovf | rej_unf;
    end
  end

  // Spill array carries no reset; count gates every read so stale slots stay hidden.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[wr_idx] <= ros_q;
    end
  end

  assign bus.tos       = tos_q;
  assign bus.nos       = nos_q;
  assign bus.ros       = ros_q;
  assign bus.count     = cnt_q;
  assign bus.empty     = (cnt_q == '0);
  assign bus.full      = is_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.op_err    = err_q;
endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: a DEPTH=8 instance and a DEPTH=4 instance driven from vector
// tables; expected states are queued on drive and compared when the result is due.
module tb_stack_unit;
  localparam logic [3:0] NOP = 4'd0, PUSH = 4'd1, DROP = 4'd2, DUP = 4'd3, SWAP = 4'd4;
  localparam logic [3:0] ROT = 4'd5, REPL1 = 4'd6, REPL2 = 4'd7, CLEAR = 4'd8, OP9 = 4'd9;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic rst_s = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stack_unit_if #(.WIDTH(16), .DEPTH(8)) bif ();
  stack_unit_if #(.WIDTH(16), .DEPTH(4)) sif ();

  stack_unit #(.WIDTH(16), .DEPTH(8)) u_big (.clk(clk), .rst(rst_b), .bus(bif.slave));
  stack_unit #(.WIDTH(16), .DEPTH(4)) u_small (.clk(clk), .rst(rst_s), .bus(sif.slave));

  typedef struct {
    logic       rst, vld, clr;
    logic [3:0] op;
    logic [15:0] d, t, n, r;
    int         c;
    logic       ov, un, er;
  } vec_t;

  typedef struct {
    bit          sel;
    int          due;
    string       name;
    logic [15:0] t, n, r;
    int          c;
    logic        ov, un, er;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  logic [15:0] vals[8];

  function automatic vec_t mk(input logic rst, input logic vld, input logic clr,
                              input logic [3:0] op, input logic [15:0] d,
                              input logic [15:0] t, input logic [15:0] n, input logic [15:0] r,
                              input int c, input logic ov, input logic un, input logic er);
    vec_t v;
    v.rst = rst; v.vld = vld; v.clr = clr; v.op = op; v.d = d;
    v.t = t; v.n = n; v.r = r; v.c = c; v.ov = ov; v.un = un; v.er = er;
    return v;
  endfunction

  function automatic logic [15:0] at_depth(input int cnt, input int pos);
    return (pos < cnt) ? vals[cnt-1-pos] : 16'h0000;
  endfunction

  task automatic apply(input bit sel, input vec_t v, input string nm);
    exp_t e;
    @(negedge clk);
    if (sel) begin
      rst_s = v.rst; sif.op_valid = v.vld; sif.op = v.op; sif.push_data = v.d; sif.clear_err = v.clr;
    end else begin
      rst_b = v.rst; bif.op_valid = v.vld; bif.op = v.op; bif.push_data = v.d; bif.clear_err = v.clr;
    end
    e.sel = sel; e.due = cyc + 1; e.name = nm;
    e.t = v.t; e.n = v.n; e.r = v.r; e.c = v.c; e.ov = v.ov; e.un = v.un; e.er = v.er;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    rst_b = 1'b0; bif.op_valid = 1'b0; bif.op = NOP; bif.clear_err = 1'b0;
    rst_s = 1'b0; sif.op_valid = 1'b0; sif.op = NOP; sif.clear_err = 1'b0;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      logic [15:0] at, an, ar;
      int ac, dep;
      logic ae, af, aov, aun, aer, xe, xf;
      e = sb.pop_front();
      if (e.sel) begin
        at = sif.tos; an = sif.nos; ar = sif.ros; ac = int'(sif.count); ae = sif.empty;
        af = sif.full; aov = sif.overflow; aun = sif.underflow; aer = sif.op_err; dep = 4;
      end else begin
        at = bif.tos; an = bif.nos; ar = bif.ros; ac = int'(bif.count); ae = bif.empty;
        af = bif.full; aov = bif.overflow; aun = bif.underflow; aer = bif.op_err; dep = 8;
      end
      xe = (e.c == 0);
      xf = (e.c == dep);
      n_vec++;
      if (e.due != cyc || at !== e.t || an !== e.n || ar !== e.r || ac != e.c || ae !== xe ||
          af !== xf || aov !== e.ov || aun !== e.un || aer !== e.er) begin
        n_bad++;
        $display("FAIL %s cyc=%0d got tos=%h nos=%h ros=%h cnt=%0d e=%b f=%b ov=%b un=%b err=%b want tos=%h nos=%h ros=%h cnt=%0d e=%b f=%b ov=%b un=%b err=%b",
                 e.name, cyc, at, an, ar, ac, ae, af, aov, aun, aer,
                 e.t, e.n, e.r, e.c, xe, xf, e.ov, e.un, e.er);
      end
    end
  end

  initial begin
    bif.op_valid = 1'b0; bif.op = NOP; bif.push_data = '0; bif.clear_err = 1'b0;
    sif.op_valid = 1'b0; sif.op = NOP; sif.push_data = '0; sif.clear_err = 1'b0;

    //           rst  vld  clr  op     data      tos       nos       ros       cnt ov  un  er
    tbl.push_back(mk(1, 0, 0, NOP,   16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, PUSH,  16'h0011, 16'h0011, 16'h0000, 16'h0000, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, PUSH,  16'h0022, 16'h0022, 16'h0011, 16'h0000, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, PUSH,  16'h0033, 16'h0033, 16'h0022, 16'h0011, 3, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, ROT,   16'h0000, 16'h0011, 16'h0033, 16'h0022, 3, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, CLEAR, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, DROP,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, PUSH,  16'h0044, 16'h0044, 16'h0000, 16'h0000, 1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, SWAP,  16'h0000, 16'h0044, 16'h0000, 16'h0000, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, REPL2, 16'h0099, 16'h0044, 16'h0000, 16'h0000, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, NOP,   16'h0000, 16'h0044, 16'h0000, 16'h0000, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, CLEAR, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, PUSH,  16'h000A, 16'h000A, 16'h0000, 16'h0000, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, PUSH,  16'h000B, 16'h000B, 16'h000A, 16'h0000, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, PUSH,  16'h000C, 16'h000C, 16'h000B, 16'h000A, 3, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, PUSH,  16'h000D, 16'h000D, 16'h000C, 16'h000B, 4, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, PUSH,  16'h000E, 16'h000E, 16'h000D, 16'h000C, 5, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, REPL2, 16'h001B, 16'h001B, 16'h000C, 16'h000B, 4, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, DROP,  16'h0000, 16'h000C, 16'h000B, 16'h000A, 3, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, DROP,  16'h0000, 16'h000B, 16'h000A, 16'h0000, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, REPL1, 16'h0055, 16'h0055, 16'h000A, 16'h0000, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, DUP,   16'h0000, 16'h0055, 16'h0055, 16'h000A, 3, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, PUSH,  16'h0066, 16'h0066, 16'h0055, 16'h0055, 4, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, DROP,  16'h0000, 16'h0055, 16'h0055, 16'h000A, 3, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, PUSH,  16'h0077, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, DROP,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, OP9,   16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, PUSH,  16'h1234, 16'h1234, 16'h0000, 16'h0000, 1, 0, 0, 0));
    foreach (tbl[i]) apply(1'b0, tbl[i], $sformatf("big_vec%0d", i));

    // DUP/DROP stream from count=1, tos=0x1234
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0)
        apply(1'b0, mk(0, 1, 0, DUP, 16'h0, 16'h1234, 16'h1234, 16'h0, 2, 0, 0, 0), "dupdrop_dup");
      else
        apply(1'b0, mk(0, 1, 0, DROP, 16'h0, 16'h1234, 16'h0, 16'h0, 1, 0, 0, 0), "dupdrop_drop");
    end

    // Fill the DEPTH=8 stack through the spill array, overflow, then drain back past empty
    vals[0] = 16'h1234;
    for (int k = 1; k < 8; k++) begin
      vals[k] = 16'h0100 + 16'(k);
      apply(1'b0, mk(0, 1, 0, PUSH, vals[k], at_depth(k+1, 0), at_depth(k+1, 1), at_depth(k+1, 2),
                     k+1, 0, 0, 0), "fill_push");
    end
    apply(1'b0, mk(0, 1, 0, PUSH, 16'h0999, vals[7], vals[6], vals[5], 8, 1, 0, 1), "big_ovf");
    apply(1'b0, mk(0, 0, 0, NOP, 16'h0, vals[7], vals[6], vals[5], 8, 1, 0, 0), "big_ovf_hold");
    apply(1'b0, mk(0, 0, 1, NOP, 16'h0, vals[7], vals[6], vals[5], 8, 0, 0, 0), "big_ovf_clr");
    for (int c = 7; c >= 0; c--)
      apply(1'b0, mk(0, 1, 0, DROP, 16'h0, at_depth(c, 0), at_depth(c, 1), at_depth(c, 2),
                     c, 0, 0, 0), "drain_drop");
    apply(1'b0, mk(0, 1, 0, DROP, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 1, 1), "drain_unf");

    // DEPTH=4 instance: overflow, one-cycle op_err, clear, refill from a one-entry array
    apply(1'b1, mk(1, 0, 0, NOP,  16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0), "sm_reset");
    apply(1'b1, mk(0, 1, 0, PUSH, 16'h1, 16'h1, 16'h0, 16'h0, 1, 0, 0, 0), "sm_push1");
    apply(1'b1, mk(0, 1, 0, PUSH, 16'h2, 16'h2, 16'h1, 16'h0, 2, 0, 0, 0), "sm_push2");
    apply(1'b1, mk(0, 1, 0, PUSH, 16'h3, 16'h3, 16'h2, 16'h1, 3, 0, 0, 0), "sm_push3");
    apply(1'b1, mk(0, 1, 0, PUSH, 16'h4, 16'h4, 16'h3, 16'h2, 4, 0, 0, 0), "sm_push4_full");
    apply(1'b1, mk(0, 1, 0, PUSH, 16'h5, 16'h4, 16'h3, 16'h2, 4, 1, 0, 1), "sm_push5_ovf");
    apply(1'b1, mk(0, 0, 0, NOP,  16'h0, 16'h4, 16'h3, 16'h2, 4, 1, 0, 0), "sm_err_pulse");
    apply(1'b1, mk(0, 0, 1, NOP,  16'h0, 16'h4, 16'h3, 16'h2, 4, 0, 0, 0), "sm_clear_err");
    apply(1'b1, mk(0, 1, 0, DROP, 16'h0, 16'h3, 16'h2, 16'h1, 3, 0, 0, 0), "sm_drop_refill");
    apply(1'b1, mk(0, 1, 0, DROP, 16'h0, 16'h2, 16'h1, 16'h0, 2, 0, 0, 0), "sm_drop2");
    apply(1'b1, mk(0, 1, 0, DUP,  16'h0, 16'h2, 16'h2, 16'h1, 3, 0, 0, 0), "sm_dup");
    apply(1'b1, mk(0, 1, 0, PUSH, 16'h7, 16'h7, 16'h2, 16'h2, 4, 0, 0, 0), "sm_push7");
    apply(1'b1, mk(0, 1, 0, DUP,  16'h0, 16'h7, 16'h2, 16'h2, 4, 1, 0, 1), "sm_dup_ovf");
    apply(1'b1, mk(0, 1, 1, DROP, 16'h0, 16'h2, 16'h2, 16'h1, 3, 0, 0, 0), "sm_drop_clr");
    apply(1'b1, mk(0, 1, 0, ROT,  16'h0, 16'h1, 16'h2, 16'h2, 3, 0, 0, 0), "sm_rot");

    idle();
    repeat (3) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
